// File: rtl/captura_operacion_if.sv
// Keypad-to-calculator link: key code/select from the cursor block, display value and status back.
interface captura_operacion_if #(
    parameter int W = 16
);
    logic [4:0]   Pos;
    logic         sel;
    logic [W-1:0] display;
    logic [2:0]   ndig;
    logic [2:0]   op_pend;
    logic         busy;
    logic         err;

    modport master (output Pos, sel, input display, ndig, op_pend, busy, err);
    modport slave  (input Pos, sel, output display, ndig, op_pend, busy, err);
endinterface

// File: rtl/captura_operacion.sv
// Hex keypad calculator: two operands, + - x / with a restoring divider, registered display/status.
// Define SQRT_EN to build the 8-step integer square root (key 9); undefined, key 9 is a no-op.
module captura_operacion #(
    parameter int NDIG    = 4,
    parameter int DIV_CYC = 16
) (
    input logic                clk,
    input logic                rst_n,
    captura_operacion_if.slave bus
);
    localparam int W  = 4 * NDIG;
    localparam int CW = $clog2(DIV_CYC + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV_CYC);
    localparam logic [2:0] ND_MAX = 3'(NDIG);
    localparam logic [4:0] K_EQ = 5'd4, K_BS = 5'd14, K_AC = 5'd19, K_CE = 5'd24;
    localparam logic [2:0] OP_NONE = 3'd0, OP_ADD = 3'd1, OP_SUB = 3'd2, OP_MUL = 3'd3, OP_DIV = 3'd4;
`ifdef SQRT_EN
    localparam logic [4:0] K_RAIZ = 5'd9;
    localparam logic [2:0] OP_SQRT = 3'd5;
    localparam logic [CW-1:0] SQ_LAST = CW'(W / 2);
`endif

    typedef enum logic [2:0] {ENT_A, ENT_B, CALC, RES, ERR} state_t;

    state_t        state_q;
    logic [W-1:0]  a_q, b_q, disp_q, rem_q, quo_q;
    logic [2:0]    nd_q, op_q;
    logic          busy_q, err_q;
    logic [CW-1:0] cnt_q;
`ifdef SQRT_EN
    logic [W/2-1:0] root_q;
`endif

    logic       is_dig, is_op, clr_all;
    logic [3:0] dig;
    logic [2:0] op_key;

    // Keypad layout maps four rows of codes onto hex digit groups.
    always_comb begin
        is_dig = 1'b1;
        dig    = '0;
        if (bus.Pos >= 5'd20 && bus.Pos <= 5'd23)      dig = 4'(bus.Pos - 5'd20);
        else if (bus.Pos >= 5'd15 && bus.Pos <= 5'd18) dig = 4'(bus.Pos - 5'd11);
        else if (bus.Pos >= 5'd10 && bus.Pos <= 5'd13) dig = 4'(bus.Pos - 5'd2);
        else if (bus.Pos >= 5'd5 && bus.Pos <= 5'd8)   dig = 4'(bus.Pos + 5'd7);
        else                                           is_dig = 1'b0;
    end

    assign is_op   = (bus.Pos <= 5'd3);
    assign op_key  = 3'(bus.Pos + 5'd1);
    assign clr_all = bus.sel && (state_q != CALC) &&
                     ((bus.Pos == K_AC) || ((bus.Pos == K_CE) && (state_q == RES || state_q == ERR)));

    logic [W:0]     sum, dif, div_sh;
    logic [2*W-1:0] prod;
    logic           div_ge, calc_done, calc_err;
    logic [W-1:0]   calc_res;

    assign sum    = {1'b0, a_q} + {1'b0, b_q};
    assign dif    = {1'b0, a_q} - {1'b0, b_q};
    assign prod   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    assign div_sh = {rem_q, quo_q[W-1]};
    assign div_ge = (div_sh >= {1'b0, b_q});

`ifdef SQRT_EN
    logic [W-1:0] sq_sh, sq_trial;
    logic         sq_ge;
    assign sq_sh    = {rem_q[W-3:0], quo_q[W-1:W-2]};
    assign sq_trial = {{(W/2-2){1'b0}}, root_q, 2'b01};
    assign sq_ge    = (sq_sh >= sq_trial);
`endif

    always_comb begin
        calc_done = 1'b1;
        calc_err  = 1'b0;
        calc_res  = a_q;
        case (op_q)
            OP_ADD: begin calc_err = sum[W]; calc_res = sum[W-1:0]; end
            OP_SUB: begin calc_err = dif[W]; calc_res = dif[W-1:0]; end
            OP_MUL: begin calc_err = |prod[2*W-1:W]; calc_res = prod[W-1:0]; end
            OP_DIV: begin
                calc_err  = (b_q == '0);
                calc_done = calc_err || (cnt_q == DIV_LAST);
                calc_res  = quo_q;
            end
`ifdef SQRT_EN
            OP_SQRT: begin
                calc_done = (cnt_q == SQ_LAST);
                calc_res  = {{(W/2){1'b0}}, root_q};
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ENT_A;
            a_q     <= '0;
            b_q     <= '0;
            disp_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            nd_q    <= '0;
            op_q    <= OP_NONE;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef SQRT_EN
            root_q  <= '0;
`endif
        end else if (state_q == CALC) begin
            if (calc_done) begin
                busy_q <= 1'b0;
                op_q   <= OP_NONE;
                nd_q   <= '0;
                if (calc_err) begin
                    state_q <= ERR;
                    err_q   <= 1'b1;
                    disp_q  <= '0;
                end else begin
                    state_q <= RES;
                    a_q     <= calc_res;
                    disp_q  <= calc_res;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (op_q == OP_DIV) begin
                    rem_q <= div_ge ? W'(div_sh - {1'b0, b_q}) : div_sh[W-1:0];
                    quo_q <= {quo_q[W-2:0], div_ge};
                end
`ifdef SQRT_EN
                else begin
                    rem_q  <= sq_ge ? sq_sh - sq_trial : sq_sh;
                    quo_q  <= {quo_q[W-3:0], 2'b00};
                    root_q <= {root_q[W/2-2:0], sq_ge};
                end
`endif
            end
        end else begin
            // Iteration registers track A while idle, so every entry into CALC starts preloaded.
            quo_q <= a_q;
            rem_q <= '0;
            cnt_q <= '0;
`ifdef SQRT_EN
            root_q <= '0;
`endif
            if (clr_all) begin
                state_q <= ENT_A;
                a_q     <= '0;
                b_q     <= '0;
                disp_q  <= '0;
                nd_q    <= '0;
                op_q    <= OP_NONE;
                err_q   <= 1'b0;
            end else if (bus.sel) begin
                case (state_q)
                    ENT_A: begin
                        if (is_dig) begin
                            if (nd_q < ND_MAX) begin
                                a_q    <= {a_q[W-5:0], dig};
                                disp_q <= {a_q[W-5:0], dig};
                                nd_q   <= nd_q + 3'd1;
                            end
                        end else if (bus.Pos == K_BS) begin
                            a_q    <= a_q >> 4;
                            disp_q <= a_q >> 4;
                            nd_q   <= (nd_q == '0) ? '0 : nd_q - 3'd1;
                        end else if (is_op) begin
                            op_q    <= op_key;
                            b_q     <= '0;
                            disp_q  <= '0;
                            nd_q    <= '0;
                            state_q <= ENT_B;
                        end else if (bus.Pos == K_CE) begin
                            a_q    <= '0;
                            disp_q <= '0;
                            nd_q   <= '0;
                        end
`ifdef SQRT_EN
                        else if (bus.Pos == K_RAIZ) begin
                            op_q    <= OP_SQRT;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
`endif
                    end
                    ENT_B: begin
                        if (is_dig) begin
                            if (nd_q < ND_MAX) begin
                                b_q    <= {b_q[W-5:0], dig};
                                disp_q <= {b_q[W-5:0], dig};
                                nd_q   <= nd_q + 3'd1;
                            end
                        end else if (bus.Pos == K_BS) begin
                            b_q    <= b_q >> 4;
                            disp_q <= b_q >> 4;
                            nd_q   <= (nd_q == '0) ? '0 : nd_q - 3'd1;
                        end else if (is_op) begin
                            if (nd_q == '0) op_q <= op_key;
                        end else if (bus.Pos == K_EQ) begin
                            if (nd_q == '0) b_q <= '0;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end else if (bus.Pos == K_CE) begin
                            b_q    <= '0;
                            disp_q <= '0;
                            nd_q   <= '0;
                        end
                    end
                    RES: begin
                        if (is_dig) begin
                            a_q     <= {{(W-4){1'b0}}, dig};
                            disp_q  <= {{(W-4){1'b0}}, dig};
                            nd_q    <= 3'd1;
                            state_q <= ENT_A;
                        end else if (is_op) begin
                            op_q    <= op_key;
                            b_q     <= '0;
                            disp_q  <= '0;
                            nd_q    <= '0;
                            state_q <= ENT_B;
                        end
`ifdef SQRT_EN
                        else if (bus.Pos == K_RAIZ) begin
                            op_q    <= OP_SQRT;
                            busy_q  <= 1'b1;
                            state_q <= CALC;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.display = disp_q;
    assign bus.ndig    = nd_q;
    assign bus.op_pend = op_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_captura_operacion.sv
// Scoreboarded bench for captura_operacion: key presses update a calculator model, a monitor checks outputs.
module tb_captura_operacion;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    captura_operacion_if ifc ();
    captura_operacion #(.NDIG(4), .DIV_CYC(16)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

    typedef struct {
        int disp;
        int nd;
        int op;
        int err;
        int bcyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   skip_mon = 1'b0;

    localparam int MA = 0, MB = 1, MR = 2, ME = 3;
    int m_a, m_b, m_nd, m_op, m_err, m_mode;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic int hexval(input int k);
        if (k >= 20 && k <= 23) return k - 20;
        if (k >= 15 && k <= 18) return k - 11;
        if (k >= 10 && k <= 13) return k - 2;
        if (k >= 5 && k <= 8)   return k + 7;
        return -1;
    endfunction

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_nd = 0; m_op = 0; m_err = 0; m_mode = MA;
    endtask

    task automatic model_calc(output int cyc);
        longint res = 0;
        bit     bad = 1'b0;
        cyc = 1;
        case (m_op)
            1: begin res = m_a + m_b; bad = (res > 65535); end
            2: begin bad = (m_b > m_a); res = m_a - m_b; end
            3: begin res = longint'(m_a) * longint'(m_b); bad = (res > 65535); end
            4: begin
                if (m_b == 0) bad = 1'b1;
                else begin res = m_a / m_b; cyc = 17; end
            end
            5: begin res = isqrt(m_a); cyc = 9; end
            default: res = m_a;
        endcase
        m_op = 0;
        m_nd = 0;
        if (bad) begin m_mode = ME; m_err = 1; end
        else begin m_mode = MR; m_a = int'(res); end
    endtask

    task automatic model_key(input int k, output exp_t e);
        int d;
        d = hexval(k);
        e.bcyc = 0;
        if (k == 19 || (k == 24 && (m_mode == MR || m_mode == ME))) model_clear();
        else case (m_mode)
            MA: begin
                if (d >= 0) begin
                    if (m_nd < 4) begin m_a = m_a * 16 + d; m_nd++; end
                end else if (k == 14) begin
                    m_a = m_a / 16;
                    if (m_nd > 0) m_nd--;
                end else if (k <= 3) begin
                    m_op = k + 1; m_b = 0; m_nd = 0; m_mode = MB;
                end else if (k == 24) begin
                    m_a = 0; m_nd = 0;
                end
`ifdef SQRT_EN
                else if (k == 9) begin m_op = 5; model_calc(e.bcyc); end
`endif
            end
            MB: begin
                if (d >= 0) begin
                    if (m_nd < 4) begin m_b = m_b * 16 + d; m_nd++; end
                end else if (k == 14) begin
                    m_b = m_b / 16;
                    if (m_nd > 0) m_nd--;
                end else if (k <= 3) begin
                    if (m_nd == 0) m_op = k + 1;
                end else if (k == 4) begin
                    model_calc(e.bcyc);
                end else if (k == 24) begin
                    m_b = 0; m_nd = 0;
                end
            end
            MR: begin
                if (d >= 0) begin
                    m_a = d; m_nd = 1; m_mode = MA;
                end else if (k <= 3) begin
                    m_op = k + 1; m_b = 0; m_nd = 0; m_mode = MB;
                end
`ifdef SQRT_EN
                else if (k == 9) begin m_op = 5; model_calc(e.bcyc); end
`endif
            end
            default: ;
        endcase
        e.disp = (m_err != 0) ? 0 : ((m_mode == MB) ? m_b : m_a);
        e.nd   = m_nd;
        e.op   = m_op;
        e.err  = m_err;
    endtask

    task automatic press(input int k);
        exp_t e;
        int   n;
        @(negedge clk);
        ifc.Pos = 5'(k);
        ifc.sel = 1'b1;
        model_key(k, e);
        q.push_back(e);
        @(negedge clk);
        ifc.sel = 1'b0;
        n = 0;
        while ((ifc.busy === 1'b1 || q.size() > 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Monitor: every accepted key press yields one settled output set plus a busy duration.
    initial begin
        exp_t e;
        int   cyc;
        forever begin
            @(posedge clk);
            if (ifc.sel === 1'b1 && !skip_mon && rst_n === 1'b1) begin
                #1;
                cyc = 0;
                while (ifc.busy === 1'b1 && cyc < 64) begin
                    cyc++;
                    @(posedge clk);
                    #1;
                end
                if (q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
                else begin
                    e = q.pop_front();
                    chk("display", 32'(ifc.display), 32'(e.disp));
                    chk("ndig", 32'(ifc.ndig), 32'(e.nd));
                    chk("op_pend", 32'(ifc.op_pend), 32'(e.op));
                    chk("err", 32'(ifc.err), 32'(e.err));
                    chk("busy_cycles", 32'(cyc), 32'(e.bcyc));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        ifc.Pos = '0;
        ifc.sel = 1'b0;
        model_clear();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_display", 32'(ifc.display), 32'd0);
        chk("reset_ndig", 32'(ifc.ndig), 32'd0);
        chk("reset_op", 32'(ifc.op_pend), 32'd0);
        chk("reset_busy", 32'(ifc.busy), 32'd0);
        chk("reset_err", 32'(ifc.err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 12 + 3
        press(21); press(22); press(0); press(23); press(4);
        chk("plan_add", 32'(ifc.display), 32'h15);
        // 0xCF00 / 0x10
        press(19); press(5); press(8); press(20); press(20); press(3); press(21); press(20); press(4);
        chk("plan_div", 32'(ifc.display), 32'h0CF0);
        // 2 - 3 -> error, "=" ignored, AC recovers
        press(19); press(22); press(1); press(23); press(4);
        chk("plan_sub_err", 32'(ifc.err), 32'd1);
        press(4); press(19);
        chk("plan_ac_err", 32'(ifc.err), 32'd0);
        // fifth digit dropped, then backspace
        press(21); press(22); press(23); press(15); press(16);
        chk("plan_5th_digit", 32'(ifc.display), 32'h1234);
        press(14);
        chk("plan_backspace", 32'(ifc.display), 32'h0123);
        // 7 x 2, chained + 1, then new digit
        press(19); press(18); press(2); press(22); press(4);
        chk("plan_mul", 32'(ifc.display), 32'h000E);
        press(0); press(21); press(4);
        chk("plan_chain", 32'(ifc.display), 32'h000F);
        press(22);
        chk("plan_new_a", 32'(ifc.display), 32'h0002);
        // square root of 0x51
        press(19); press(16); press(21); press(9);
`ifdef SQRT_EN
        chk("plan_sqrt", 32'(ifc.display), 32'h0009);
`else
        chk("plan_no_sqrt", 32'(ifc.display), 32'h0051);
`endif
        // boundaries: add carry, mul overflow, divide by zero, operator replacement, C in ENT_B
        press(19); press(8); press(8); press(8); press(8); press(0); press(21); press(4);
        press(19); press(21); press(20); press(20); press(2); press(21); press(20); press(20); press(4);
        press(19); press(22); press(3); press(4);
        press(24);
        press(23); press(0); press(1); press(2); press(21); press(24); press(22); press(4);

        for (int i = 0; i < 400; i++) press(int'($urandom_range(0, 31)));

        // reset in the middle of a divide
        press(19); press(5); press(8); press(20); press(20); press(3); press(21); press(20);
        skip_mon = 1'b1;
        @(negedge clk);
        ifc.Pos = 5'd4;
        ifc.sel = 1'b1;
        @(negedge clk);
        ifc.sel = 1'b0;
        repeat (5) @(negedge clk);
        chk("middiv_busy", 32'(ifc.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("middiv_display", 32'(ifc.display), 32'd0);
        chk("middiv_ndig", 32'(ifc.ndig), 32'd0);
        chk("middiv_op", 32'(ifc.op_pend), 32'd0);
        chk("middiv_busy_rst", 32'(ifc.busy), 32'd0);
        chk("middiv_err", 32'(ifc.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (20) @(negedge clk);
        chk("after_release_display", 32'(ifc.display), 32'd0);
        chk("after_release_busy", 32'(ifc.busy), 32'd0);
        skip_mon = 1'b0;
        press(21); press(0); press(22); press(4);
        chk("post_reset_add", 32'(ifc.display), 32'h3);

        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
